// File: rtl/dmem.sv
// Word-organised data memory behind the LSU port: byte-lane writes, right-justified
// reads, misaligned/illegal detection and a configurable wait-state delay.
module dmem #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic              mem_r,
  input  logic [XLEN/8-1:0] mem_w,
  input  logic [XLEN-1:0]   mem_din,
  output logic [XLEN-1:0]   mem_dout,
  output logic              mem_ready,
  output logic              mem_err
);

  // state  | meaning
  // S_IDLE | waiting for a request, inputs sampled here only
  // S_WAIT | counting wait states on the latched request
  // S_RESP | mem_ready/mem_err/mem_dout presented for one cycle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      off_q, off_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [NB-1:0]   mask_q, mask_d;
  logic [XLEN-1:0] din_q, din_d;
  logic            rd_q, rd_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] dout_q, dout_d;

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            req, accept, go_resp, bad, commit;
  logic [1:0]      cur_off;
  logic [AW-1:0]   cur_idx;
  logic [NB-1:0]   cur_mask;
  logic [XLEN-1:0] cur_din;
  logic            cur_rd;
  logic [NB+2:0]   lmask;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rword;
  logic            unused_addr;

  assign unused_addr = ^mem_addr[XLEN-1:AW+2];

  assign req    = mem_r | (|mem_w);
  assign accept = (state_q == S_IDLE) && req;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live inputs stand in for the not-yet-latched copies.
  assign cur_off  = accept ? mem_addr[1:0]    : off_q;
  assign cur_idx  = accept ? mem_addr[AW+1:2] : idx_q;
  assign cur_mask = accept ? mem_w            : mask_q;
  assign cur_din  = accept ? mem_din          : din_q;
  assign cur_rd   = accept ? mem_r            : rd_q;

  assign lmask   = {3'b000, cur_mask} << cur_off;
  assign bad     = (|lmask[NB+2:NB]) || (cur_rd && (|cur_mask));
  assign go_resp = (accept && (WAIT_CYCLES == 0)) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign commit  = rst_n && go_resp && !bad && !cur_rd;
  assign wdata   = cur_din << {cur_off, 3'b000};
  assign rword   = mem_q[cur_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    din_d   = din_q;
    rd_d    = rd_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    dout_d  = dout_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          off_d  = mem_addr[1:0];
          idx_d  = mem_addr[AW+1:2];
          mask_d = mem_w;
          din_d  = mem_din;
          rd_d   = mem_r;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (go_resp) begin
      ready_d = 1'b1;
      err_d   = bad;
      if (cur_rd && !bad) dout_d = rword >> {cur_off, 3'b000};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      off_q   <= 2'd0;
      idx_q   <= '0;
      mask_q  <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Array has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < NB; i++) begin
        if (lmask[i]) mem_q[cur_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign mem_dout  = dout_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_dmem.sv
// Scoreboard bench for dmem: two instances (1 and 3 wait states) driven by directed
// requests; a negedge monitor pops expected responses and checks data, error and timing.
module tb_dmem;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn  [2];
  logic [31:0] addr  [2];
  logic        rd    [2];
  logic [3:0]  wm    [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];
  logic        ready [2];
  logic        err   [2];

  dmem #(.XLEN(32), .DEPTH(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rstn[0]), .mem_addr(addr[0]), .mem_r(rd[0]), .mem_w(wm[0]),
    .mem_din(din[0]), .mem_dout(dout[0]), .mem_ready(ready[0]), .mem_err(err[0])
  );

  dmem #(.XLEN(32), .DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rstn[1]), .mem_addr(addr[1]), .mem_r(rd[1]), .mem_w(wm[1]),
    .mem_din(din[1]), .mem_dout(dout[1]), .mem_ready(ready[1]), .mem_err(err[1])
  );

  typedef struct {
    logic        e;
    logic [31:0] d;
    int          at;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   wc [2] = '{1, 3};
  bit   b2b [2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ready[d] === 1'b1) begin
        exp_t x;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          checks++;
          $display("FAIL unexpected_ready dut%0d: got ready=1 expected no response (cycle %0d)", d, cyc);
        end else begin
          x = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk({x.name, "_err"},  32'(err[d]), 32'(x.e));
          chk({x.name, "_dout"}, dout[d], x.d);
          chk({x.name, "_cyc"},  cyc, x.at);
        end
      end else begin
        chk($sformatf("err_without_ready_dut%0d", d), 32'(err[d]), 32'd0);
      end
    end
  end

  task automatic req(input int d, input string nm, input logic [31:0] a, input logic r,
                     input logic [3:0] m, input logic [31:0] dat,
                     input logic e, input logic [31:0] exp_d);
    exp_t x;
    int   n;
    addr[d] = a; rd[d] = r; wm[d] = m; din[d] = dat;
    x.e = e; x.d = exp_d; x.name = nm;
    x.at = cyc + wc[d] + 1 + (b2b[d] ? 1 : 0);
    if (d == 0) q0.push_back(x); else q1.push_back(x);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready[d] !== 1'b1 && n < 20);
    if (ready[d] !== 1'b1) begin
      checks++;
      $display("FAIL %s_timeout: got no mem_ready expected one within 20 cycles", nm);
    end
    b2b[d] = 1'b1;
  endtask

  task automatic idle(input int d);
    rd[d] = 1'b0; wm[d] = 4'h0; addr[d] = 32'h0; din[d] = 32'h0;
    @(negedge clk);
    b2b[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; addr[d] = 32'h0; rd[d] = 1'b0; wm[d] = 4'h0; din[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready_dut%0d", d), 32'(ready[d]), 32'd0);
      chk($sformatf("reset_err_dut%0d", d),   32'(err[d]),   32'd0);
      chk($sformatf("reset_dout_dut%0d", d),  dout[d],       32'd0);
    end
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    @(negedge clk);

    // basic store/load
    req(0, "t1_sw",      32'h10, 1'b0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);        idle(0);
    req(0, "t1_lw",      32'h10, 1'b1, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF); idle(0);

    // byte lanes
    req(0, "t2_sw",      32'h20, 1'b0, 4'hF, 32'h11223344, 1'b0, 32'hDEADBEEF); idle(0);
    req(0, "t2_sb",      32'h22, 1'b0, 4'h1, 32'hFFFFFFAA, 1'b0, 32'hDEADBEEF); idle(0);
    req(0, "t2_sh",      32'h20, 1'b0, 4'h3, 32'h9999BBCC, 1'b0, 32'hDEADBEEF); idle(0);
    req(0, "t2_lw",      32'h20, 1'b1, 4'h0, 32'h0,        1'b0, 32'h11AABBCC); idle(0);
    req(0, "t2_lb23",    32'h23, 1'b1, 4'h0, 32'h0,        1'b0, 32'h00000011); idle(0);

    // misaligned stores
    req(0, "t3_sh23",    32'h23, 1'b0, 4'h3, 32'h0000FFFF, 1'b1, 32'h00000011); idle(0);
    req(0, "t3_sw21",    32'h21, 1'b0, 4'hF, 32'h55555555, 1'b1, 32'h00000011); idle(0);
    req(0, "t3_lw",      32'h20, 1'b1, 4'h0, 32'h0,        1'b0, 32'h11AABBCC); idle(0);

    // illegal read+write
    req(0, "t4_illegal", 32'h20, 1'b1, 4'h3, 32'h00005555, 1'b1, 32'h11AABBCC); idle(0);
    req(0, "t4_lw",      32'h20, 1'b1, 4'h0, 32'h0,        1'b0, 32'h11AABBCC); idle(0);
    req(0, "t4_lw21",    32'h21, 1'b1, 4'h0, 32'h0,        1'b0, 32'h0011AABB); idle(0);

    // aliasing with continuous back-to-back requests
    req(0, "t5_sw1000",  32'h1000, 1'b0, 4'hF, 32'h00000005, 1'b0, 32'h0011AABB);
    req(0, "t5_lw0",     32'h0,    1'b1, 4'h0, 32'h0,        1'b0, 32'h00000005);
    req(0, "t5_lw1000",  32'h1000, 1'b1, 4'h0, 32'h0,        1'b0, 32'h00000005);
    req(0, "t5_sb3",     32'h3,    1'b0, 4'h1, 32'h12345677, 1'b0, 32'h00000005);
    req(0, "t5_lw0b",    32'h0,    1'b1, 4'h0, 32'h0,        1'b0, 32'h77000005);
    idle(0);

    // reset during wait drops the uncommitted write
    req(1, "t6_sw_old",  32'h40, 1'b0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);        idle(1);
    req(1, "t6_lw_old",  32'h40, 1'b1, 4'h0, 32'h0,        1'b0, 32'hCAFEF00D); idle(1);
    addr[1] = 32'h40; rd[1] = 1'b0; wm[1] = 4'hF; din[1] = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    rstn[1] = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(ready[1]), 32'd0);
    chk("t6_rst_err",   32'(err[1]),   32'd0);
    chk("t6_rst_dout",  dout[1],       32'd0);
    rd[1] = 1'b0; wm[1] = 4'h0; addr[1] = 32'h0; din[1] = 32'h0;
    @(negedge clk);
    rstn[1] = 1'b1;
    @(negedge clk);
    b2b[1] = 1'b0;
    req(1, "t6_lw_after", 32'h40, 1'b1, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D); idle(1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem.md
# dmem

Data-memory responder at the far end of the core's load/store port. Accepts lane-0-aligned read strobes and write byte masks from the LSU, together with a byte address and store data. Performs the access on an internal word-organised array after a configurable number of wait states. Returns the read word right-justified to the addressed byte, with a one-cycle `mem_ready` pulse.

## Interface
- `XLEN`, 32: data width; only 32 is supported (4 byte lanes).
- `DEPTH`, 1024: array size in words; must be a power of two ≥ 2.
- `WAIT_CYCLES`, 1: wait states between acceptance and response (0..15).

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_addr` in XLEN: byte address of the access.
- `mem_r` in 1: read request.
- `mem_w` in XLEN/8: write byte mask, lane-0 aligned (0001 = SB, 0011 = SH, 1111 = SW).
- `mem_din` in XLEN: store data, lane-0 aligned.
- `mem_dout` out XLEN: read data, addressed byte in bits [7:0].
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_err` out 1: misaligned/illegal flag, valid only while `mem_ready` = 1.

## Operation
- Request present = `mem_r` | (|`mem_w`).
- The request is sampled only in IDLE, at a rising edge. The requester holds inputs stable until it sees `mem_ready`.
- Latched at acceptance: `off` = `mem_addr[1:0]`, word index `mem_addr[$clog2(DEPTH)+1:2]`, mask, data, read flag.
- Upper address bits are ignored, so addresses alias modulo DEPTH*4.
- Write lanes: `lmask` = `mask << off` (4-bit result plus carry-out bits).
- Misaligned: any mask bit shifted past lane 3. Examples: SH with off = 3; SW with off ≠ 0.
- Illegal: `mem_r` and nonzero `mem_w` at the same time.
- Error case (misaligned or illegal): no array access, `mem_dout` unchanged, `mem_err` = 1 in the response cycle.
- Write: for each set lane i of `lmask`, array byte i ← byte (i − off) of `mem_din`. Other bytes are untouched.
- Read: `mem_dout` ← `word >> (8*off)`, zero-filled in the upper bytes. Reads are never misaligned; the LSU selects width and extension.
- Writes leave `mem_dout` unchanged.
- FSM:
  - IDLE → WAIT on request if `WAIT_CYCLES` > 0, else IDLE → RESP.
  - WAIT: counter counts `WAIT_CYCLES` cycles, then → RESP.
  - RESP → IDLE unconditionally.
- Array access (commit or read capture) happens on the edge entering RESP.
- The array is not reset and powers up undefined.

## Timing
- Reset values: state IDLE, counter 0, `mem_ready` 0, `mem_err` 0, `mem_dout` 0.
- Acceptance edge E0. `mem_ready`/`mem_err`/`mem_dout` are valid in the cycle after edge E0 + `WAIT_CYCLES`.
  - `WAIT_CYCLES` = 0: response in the cycle right after acceptance.
  - `WAIT_CYCLES` = 1: response 2 cycles after the request first appears.
- `mem_ready` is high exactly one cycle per accepted request. `mem_err` is 0 whenever `mem_ready` is 0.
- Back-to-back: a request present at the edge ending RESP is not sampled (FSM is in RESP). It is accepted at the following edge. Peak throughput is one access per `WAIT_CYCLES` + 2 cycles.
- Request inputs changing during WAIT/RESP are ignored; only latched values are used.
- `rst_n` low mid-operation returns the FSM to IDLE at once and clears all outputs. A write whose commit edge has not occurred is dropped. An already-committed write persists.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
1. `WAIT_CYCLES`=1:
   - Stimulus: SW addr 0x10 data 0xDEADBEEF, then LW (`mem_r`) addr 0x10.
   - Required: each response arrives 2 cycles after its request; `mem_dout` = 0xDEADBEEF; `mem_err` = 0.
2. Byte lanes:
   - Stimulus: after SW 0x11223344 @0x20, SB 0xAA @0x22 and SH 0xBBCC @0x20.
   - Required: LW @0x20 → 0x11AABBCC; read @0x23 → 0x00000011.
3. Misaligned:
   - Stimulus: SH @0x23; SW @0x21.
   - Required: both give `mem_ready` = 1 with `mem_err` = 1; LW @0x20 is unchanged.
4. Illegal:
   - Stimulus: `mem_r` = 1 with `mem_w` = 0011.
   - Required: `mem_err` = 1, no write, `mem_dout` unchanged.
5. Aliasing and throughput:
   - Stimulus: `DEPTH` = 1024; SW 0x5 @0x1000, then LW @0x0; drive requests continuously.
   - Required: LW returns 0x5; `mem_ready` pulses every 3 cycles.
6. Reset during WAIT:
   - Stimulus: `WAIT_CYCLES` = 3; pull `rst_n` low 1 cycle after accepting SW 0x12345678 @0x40, then LW @0x40.
   - Required: outputs go to 0 immediately; the read returns the old value, not 0x12345678.
